password_rule_checker: RTL

Sequential rule engine that sits directly downstream of the per-character vowel checker in the password checker datapath. It accepts a password one ASCII byte per cycle over a valid/ready handshake, forwards each byte to the vowel checker, and counts length, vowels, digits and illegal characters. After the last byte it evaluates the password against the length and content rules and reports a one-cycle `done` pulse with a pass flag and a failure code that stays held.

---
 rtl/password_rule_checker_if.sv | 25 ++
 rtl/password_rule_checker.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/password_rule_checker_if.sv
// Byte-stream and result bundle between the password source, the vowel checker
// and the rule engine. The vowel checker taps char_in directly from this bundle.
interface password_rule_checker_if;
    logic       char_valid;
    logic [7:0] char_in;
    logic       char_last;
    logic       char_abort;
    logic       is_vowel;
    logic       char_ready;
    logic       done;
    logic       pass;
    logic [4:0] fail_code;
    logic [4:0] char_count;
    logic [4:0] vowel_count;

    modport master (
        output char_valid, char_in, char_last, char_abort, is_vowel,
        input  char_ready, done, pass, fail_code, char_count, vowel_count
    );

    modport slave (
        input  char_valid, char_in, char_last, char_abort, is_vowel,
        output char_ready, done, pass, fail_code, char_count, vowel_count
    );
endinterface

// File: rtl/password_rule_checker.sv
// Per-password rule engine: counts length, vowels, digits and illegal bytes of
// a streamed password and reports pass/fail with a held failure code.
module password_rule_checker #(
    parameter int MIN_LEN    = 8,
    parameter int MAX_LEN    = 16,
    parameter int MIN_VOWELS = 1,
    parameter int MIN_DIGITS = 1
) (
    input logic                    clk,
    input logic                    rst,
    password_rule_checker_if.slave bus
);

    localparam logic [4:0] MIN_LEN_C    = 5'(MIN_LEN);
    localparam logic [4:0] MAX_LEN_C    = 5'(MAX_LEN);
    localparam logic [4:0] MIN_VOWELS_C = 5'(MIN_VOWELS);
    localparam logic [4:0] MIN_DIGITS_C = 5'(MIN_DIGITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EVAL    = 2'd2,
        REPORT  = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_next_s;

    logic       ready_s;
    logic       accept_s;
    logic       start_s;
    logic       count_s;
    logic       clear_s;
    logic       eval_s;
    logic       is_digit_s;
    logic       is_printable_s;
    logic [4:0] fail_code_s;

    logic [4:0] char_cnt_r;
    logic [4:0] vowel_cnt_r;
    logic [4:0] digit_cnt_r;
    logic       illegal_r;
    logic       done_r;
    logic       pass_r;
    logic [4:0] fail_code_r;

    // Counters stop at 31 so an over-long password can never wrap back into range
    function automatic logic [4:0] sat_inc(input logic [4:0] value, input logic en);
        logic [4:0] result;
        if (en && (value != 5'd31)) begin
            result = value + 5'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

    assign ready_s        = ((state_r == IDLE) || (state_r == COLLECT)) && !rst;
    assign accept_s       = bus.char_valid && ready_s;
    assign is_digit_s     = (bus.char_in >= 8'h30) && (bus.char_in <= 8'h39);
    assign is_printable_s = (bus.char_in >= 8'h20) && (bus.char_in <= 8'h7E);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath control strobes
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        count_s      = 1'b0;
        clear_s      = 1'b0;
        eval_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    start_s      = 1'b1;
                    state_next_s = bus.char_last ? EVAL : COLLECT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COLLECT: begin
                if (bus.char_abort) begin
                    clear_s      = 1'b1;
                    state_next_s = IDLE;
                end else if (accept_s) begin
                    count_s      = 1'b1;
                    state_next_s = bus.char_last ? EVAL : COLLECT;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            EVAL: begin
                eval_s       = 1'b1;
                state_next_s = REPORT;
            end
            REPORT: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Rule evaluation on the settled counters
    always_comb begin
        fail_code_s    = 5'b00000;
        fail_code_s[0] = char_cnt_r < MIN_LEN_C;
        fail_code_s[1] = char_cnt_r > MAX_LEN_C;
        fail_code_s[2] = vowel_cnt_r < MIN_VOWELS_C;
        fail_code_s[3] = digit_cnt_r < MIN_DIGITS_C;
        fail_code_s[4] = illegal_r;
    end

    // Counters, sticky illegal flag and held result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            char_cnt_r  <= 5'd0;
            vowel_cnt_r <= 5'd0;
            digit_cnt_r <= 5'd0;
            illegal_r   <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_code_r <= 5'd0;
        end else begin
            if (start_s) begin
                char_cnt_r  <= 5'd1;
                vowel_cnt_r <= {4'd0, bus.is_vowel};
                digit_cnt_r <= {4'd0, is_digit_s};
                illegal_r   <= !is_printable_s;
                pass_r      <= 1'b0;
                fail_code_r <= 5'd0;
            end else if (count_s) begin
                char_cnt_r  <= sat_inc(char_cnt_r, 1'b1);
                vowel_cnt_r <= sat_inc(vowel_cnt_r, bus.is_vowel);
                digit_cnt_r <= sat_inc(digit_cnt_r, is_digit_s);
                illegal_r   <= illegal_r || !is_printable_s;
            end else if (clear_s) begin
                char_cnt_r  <= 5'd0;
                vowel_cnt_r <= 5'd0;
                digit_cnt_r <= 5'd0;
                illegal_r   <= 1'b0;
            end
            if (eval_s) begin
                fail_code_r <= fail_code_s;
                pass_r      <= (fail_code_s == 5'd0);
            end
            // Registered in EVAL so the pulse lands exactly on the REPORT cycle
            done_r <= eval_s;
        end
    end

    assign bus.char_ready  = ready_s;
    assign bus.done        = done_r;
    assign bus.pass        = pass_r;
    assign bus.fail_code   = fail_code_r;
    assign bus.char_count  = char_cnt_r;
    assign bus.vowel_count = vowel_cnt_r;

endmodule
